// File: rtl/sort_frame_loader.sv
// sort_frame_loader: gathers N words into a registered frame, launches the sorter, waits for done (SORT_LOADER_SHORT_FRAME_EN adds in_last short frames padded with all-ones)
module sort_frame_loader #(
  parameter int N     = 6,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
`ifdef SORT_LOADER_SHORT_FRAME_EN
  input  logic                   in_last,
`endif
  output logic [WIDTH-1:0]       frame_data [N],
  output logic                   sort_start,
  input  logic                   sort_done,
  output logic [$clog2(N+1)-1:0] frame_len,
  output logic                   busy
);
  localparam int IW = $clog2(N);
  localparam int LW = $clog2(N+1);
  typedef enum logic [1:0] {FILL, LAUNCH, WAIT} state_t;
  state_t state;
  logic [IW-1:0] wr_idx;
  logic accept, last;
  assign in_ready = state == FILL && !rst;
  assign accept = in_valid && in_ready;
`ifdef SORT_LOADER_SHORT_FRAME_EN
  assign last = wr_idx == IW'(N-1) || in_last;
`else
  assign last = wr_idx == IW'(N-1);
`endif
  // frame capture, padding and FILL -> LAUNCH -> WAIT sequencing with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wr_idx     <= '0;
      frame_len  <= '0;
      sort_start <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < N; i++) frame_data[i] <= '0;
    end else begin
      sort_start <= 1'b0;
      case (state)
        FILL: if (accept) begin
          for (int i = 0; i < N; i++)
            if (IW'(i) == wr_idx) frame_data[i] <= in_data;
`ifdef SORT_LOADER_SHORT_FRAME_EN
            else if (in_last && IW'(i) > wr_idx) frame_data[i] <= '1;
`endif
          if (last) begin
            state      <= LAUNCH;
            wr_idx     <= '0;
            frame_len  <= LW'(wr_idx) + LW'(1);
            sort_start <= 1'b1;
            busy       <= 1'b1;
          end else begin
            wr_idx <= wr_idx + IW'(1);
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: if (sort_done) begin
          state <= FILL;
          busy  <= 1'b0;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_frame_loader.sv
// tb_sort_frame_loader: table vectors, directed corner sequences and randomized frames against an arrival-order frame model
module tb_sort_frame_loader;
  localparam int N = 6;
  localparam int W = 8;
  logic clk = 0, rst = 1, in_valid = 0, sort_done = 0;
  logic [W-1:0] in_data = '0;
`ifdef SORT_LOADER_SHORT_FRAME_EN
  logic in_last = 0;
`endif
  logic in_ready, sort_start, busy;
  logic [W-1:0] frame_data [N];
  logic [2:0] frame_len;
  int checks = 0, failures = 0, starts = 0, idx = 0, exp_len = 0, s0;
  logic [47:0] cur = '0;
  typedef struct {logic [47:0] words; int gap; logic [47:0] exp;} vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  sort_frame_loader #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef SORT_LOADER_SHORT_FRAME_EN
    .in_last(in_last),
`endif
    .frame_data(frame_data), .sort_start(sort_start), .sort_done(sort_done),
    .frame_len(frame_len), .busy(busy)
  );

  always @(negedge clk) if (sort_start) starts++;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] frame();
    logic [47:0] f;
    for (int i = 0; i < N; i++) f[47-8*i -: 8] = frame_data[i];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; sort_done = 0;
    step();
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", sort_start, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_frame", frame(), 0);
    rst = 0; cur = '0; idx = 0; exp_len = 0;
    #1;
    chk("post_rst_ready", in_ready, 1);
  endtask

  // model: accepted words land in arrival order; in_last pads the tail with all-ones
  task automatic push(input logic [7:0] d, input logic l);
    chk("push_ready", in_ready, 1);
    in_valid = 1; in_data = d;
`ifdef SORT_LOADER_SHORT_FRAME_EN
    in_last = l;
`endif
    step();
    in_valid = 0;
`ifdef SORT_LOADER_SHORT_FRAME_EN
    in_last = 0;
`endif
    cur[47-8*idx -: 8] = d;
    if (l) for (int i = idx + 1; i < N; i++) cur[47-8*i -: 8] = 8'hFF;
    idx = (l || idx == N-1) ? 0 : idx + 1;
    chk("push_slot", frame(), cur);
  endtask

  task automatic push_frame(input logic [47:0] w, input int gap);
    for (int i = 0; i < N; i++) begin
      push(w[47-8*i -: 8], 1'b0);
      if (i < N-1) begin
        chk("no_early_start", sort_start, 0);
        repeat (gap) begin
          step();
          chk("gap_start", sort_start, 0);
        end
      end
    end
  endtask

  task automatic expect_launch(input int len);
    chk("launch_start", sort_start, 1);
    chk("launch_busy", busy, 1);
    chk("launch_ready", in_ready, 0);
    chk("launch_len", frame_len, len);
    exp_len = len;
    step();
    chk("start_width", sort_start, 0);
    chk("wait_busy", busy, 1);
    chk("wait_frame", frame(), cur);
  endtask

  task automatic finish_wait(input int k, input logic noisy);
    repeat (k) begin
      in_valid = noisy & 1'($urandom); in_data = 8'($urandom);
      step();
      chk("wait_hold", frame(), cur);
      chk("wait_busy_hold", busy, 1);
      chk("wait_ready", in_ready, 0);
      chk("wait_no_start", sort_start, 0);
      chk("wait_len", frame_len, exp_len);
    end
    in_valid = 0; sort_done = 1;
    step();
    sort_done = 0;
    chk("done_busy", busy, 0);
    chk("done_ready", in_ready, 1);
    chk("done_frame", frame(), cur);
    chk("done_len", frame_len, exp_len);
  endtask

  initial begin
    tbl[0] = '{48'h05_03_09_01_07_02, 0, 48'h05_03_09_01_07_02};
    tbl[1] = '{48'h00_00_00_00_00_00, 1, 48'h00_00_00_00_00_00};
    tbl[2] = '{48'hFF_FF_FF_FF_FF_FF, 0, 48'hFF_FF_FF_FF_FF_FF};
    tbl[3] = '{48'h01_02_03_04_05_06, 2, 48'h01_02_03_04_05_06};
    tbl[4] = '{48'h80_7F_FF_00_AA_55, 0, 48'h80_7F_FF_00_AA_55};
    step();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_frame(tbl[i].words, tbl[i].gap);
      chk("tbl_frame", frame(), tbl[i].exp);
      expect_launch(6);
      finish_wait(3, 1'b0);
    end
    // backpressure: 8'h11 held through WAIT lands in slot 0 on the first FILL cycle
    push_frame(48'h10_20_30_40_50_60, 0);
    expect_launch(6);
    in_valid = 1; in_data = 8'h11;
    repeat (10) begin
      step();
      chk("bp_hold", frame(), cur);
      chk("bp_ready", in_ready, 0);
    end
    sort_done = 1;
    step();
    sort_done = 0;
    chk("bp_done_frame", frame(), cur);
    chk("bp_done_ready", in_ready, 1);
    step();
    in_valid = 0;
    cur[47:40] = 8'h11; idx = 1;
    chk("bp_slot0", frame(), cur);
    for (int i = 1; i < N; i++) push(8'(i * 3), 1'b0);
    expect_launch(6);
    // late done keeps the frame, done in FILL is ignored
    finish_wait(20, 1'b1);
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    sort_done = 1;
    step();
    sort_done = 0;
    chk("fill_done_frame", frame(), cur);
    chk("fill_done_ready", in_ready, 1);
    chk("fill_done_busy", busy, 0);
    chk("fill_done_start", sort_start, 0);
    for (int i = 2; i < N; i++) push(8'hA0 + 8'(i + 1), 1'b0);
    chk("fill_done_result", frame(), 48'hA1_A2_A3_A4_A5_A6);
    expect_launch(6);
    finish_wait(1, 1'b0);
    // reset mid-fill discards partial words
    push(8'hAA, 1'b0); push(8'hBB, 1'b0); push(8'hCC, 1'b0);
    do_reset();
    s0 = starts;
    push_frame(48'h0C_0B_0A_09_08_07, 0);
    chk("abort_frame", frame(), 48'h0C_0B_0A_09_08_07);
    expect_launch(6);
    chk("abort_starts", starts - s0, 1);
    // reset during WAIT
    step(); step();
    do_reset();
    chk("wait_rst_starts", starts - s0, 1);
    // back-to-back frames
    s0 = starts;
    push_frame(48'h31_32_33_34_35_36, 0);
    expect_launch(6);
    finish_wait(2, 1'b0);
    push_frame(48'hC6_C5_C4_C3_C2_C1, 0);
    expect_launch(6);
    finish_wait(2, 1'b0);
    chk("b2b_starts", starts - s0, 2);
    chk("b2b_frame", frame(), 48'hC6_C5_C4_C3_C2_C1);
`ifdef SORT_LOADER_SHORT_FRAME_EN
    push(8'h04, 1'b0);
    push(8'h08, 1'b1);
    chk("short_frame", frame(), 48'h04_08_FF_FF_FF_FF);
    expect_launch(2);
    finish_wait(2, 1'b0);
    for (int i = 0; i < N; i++) push(8'(i + 1), i == N-1);
    chk("last_full_frame", frame(), 48'h01_02_03_04_05_06);
    expect_launch(6);
    finish_wait(2, 1'b0);
`endif
    // randomized frames with idle gaps and ignored done pulses in FILL
    for (int f = 0; f < 20; f++) begin
      s0 = starts;
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(0, 2)) begin
          sort_done = 1'($urandom); in_data = 8'($urandom);
          step();
          sort_done = 0;
          chk("rnd_idle", frame(), cur);
          chk("rnd_idle_busy", busy, 0);
        end
        push(8'($urandom), 1'b0);
        if (i < N-1) chk("rnd_no_start", sort_start, 0);
      end
      expect_launch(6);
      finish_wait($urandom_range(0, 8), 1'b1);
      chk("rnd_starts", starts - s0, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
